// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a small byte FIFO drained over valid/ready.
// Serial input is double-flopped; framing errors and overruns pulse for one cycle.
module uart_rx_fifo #(
  parameter int unsigned ClksPerBit = 104,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam int unsigned AW   = $clog2(FifoDepth);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic            sync1_q;
  logic            rx_s_q;
  logic            prev_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            busy_q;
  logic            ferr_q;
  logic            ovr_q;

  logic [7:0]      mem_q [FifoDepth];
  logic [AW:0]     wptr_q;
  logic [AW:0]     rptr_q;

  logic fall;
  logic cnt_half;
  logic cnt_last;
  logic push;
  logic pop;
  logic empty;
  logic full;
  logic push_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      prev_q  <= rx_s_q;
    end
  end

  assign fall     = prev_q & ~rx_s_q;
  assign cnt_half = (cnt_q == CntW'(ClksPerBit / 2 - 1));
  assign cnt_last = (cnt_q == CntW'(ClksPerBit - 1));
  assign push     = (state_q == STOP) & cnt_last & rx_s_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_half) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        DATA: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        STOP: begin
          if (cnt_last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ferr_q  <= ~rx_s_q;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = ~empty & ready_i;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push & (~full | pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovr_q  <= 1'b0;
      for (int i = 0; i < int'(FifoDepth); i++) mem_q[i] <= '0;
    end else begin
      ovr_q <= push & full & ~pop;
      if (pop) rptr_q <= rptr_q + (AW+1)'(1);
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= shift_q;
        wptr_q <= wptr_q + (AW+1)'(1);
      end
    end
  end

  assign data_o      = mem_q[rptr_q[AW-1:0]];
  assign valid_o     = ~empty;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at ClksPerBit=8, FifoDepth=4.
// Inputs change on the falling clock edge; outputs are sampled there too.
module tb_uart_rx_fifo;

  localparam int CPB = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int nvec = 0;
  int nerr = 0;

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int rise_cyc = -1;
  int start_cyc = 0;
  logic valid_d = 1'b0;
  logic [7:0] popq[$];
  int low_run = 0;
  int max_gap = 0;
  bit track = 0;

  uart_rx_fifo #(.ClksPerBit(CPB), .FifoDepth(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (valid_o && !valid_d) rise_cyc = cyc;
    valid_d = valid_o;
    if (valid_o && ready_i) popq.push_back(data_o);
    if (busy_o) begin
      if (track && low_run > max_gap) max_gap = low_run;
      low_run = 0;
      track = 1;
    end else begin
      low_run++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk_i);
    rx_i = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!valid_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 200), 32'd1);
    chk(tag, 32'(data_o), 32'(exp));
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  initial begin
    logic saw;
    logic [7:0] burst [4];
    burst[0] = 8'h00; burst[1] = 8'hFF;
    burst[2] = 8'h55; burst[3] = 8'h3C;

    rst_i = 1'b1;
    rx_i = 1'b1;
    ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_flags", 32'({frame_err_o, overrun_o}), 32'd0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // single byte and latency from start edge to valid
    rise_cyc = -1;
    send(8'hA5, 1'b1);
    repeat (4) @(negedge clk_i);
    chk("a5_latency_in_window",
        32'((rise_cyc - start_cyc) >= 78 && (rise_cyc - start_cyc) <= 80),
        32'd1);
    pop_chk("a5_data", 8'hA5);
    @(negedge clk_i);
    chk("a5_empty_after_pop", 32'(valid_o), 32'd0);
    chk("a5_no_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    // back-to-back burst with consumer always ready
    popq.delete();
    ready_i = 1'b1;
    track = 0;
    max_gap = 0;
    for (int i = 0; i < 4; i++) send(burst[i], 1'b1);
    repeat (6) @(negedge clk_i);
    ready_i = 1'b0;
    chk("burst_count", 32'(popq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("burst_byte%0d", i),
          (i < popq.size()) ? 32'(popq[i]) : 32'hDEAD, 32'(burst[i]));
    chk("burst_gap_bounded",
        32'(max_gap >= 1 && max_gap <= CPB / 2), 32'd1);

    // overrun: six bytes into a four-deep FIFO with no consumer
    ov_cnt = 0;
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b1);
    repeat (4) @(negedge clk_i);
    chk("ovr_pulses", 32'(ov_cnt), 32'd2);
    chk("ovr_no_ferr", 32'(fe_cnt), 32'd0);
    for (int i = 1; i <= 4; i++)
      pop_chk($sformatf("ovr_drain%0d", i), 8'(i));
    @(negedge clk_i);
    chk("ovr_empty", 32'(valid_o), 32'd0);

    // framing error then clean recovery
    ov_cnt = 0;
    send(8'h7E, 1'b0);
    repeat (4) @(negedge clk_i);
    chk("ferr_pulse", 32'(fe_cnt), 32'd1);
    chk("ferr_no_byte", 32'(valid_o), 32'd0);
    repeat (2 * CPB) @(negedge clk_i);
    send(8'h42, 1'b1);
    pop_chk("ferr_recover", 8'h42);
    chk("ferr_flags_after", 32'(fe_cnt * 16 + ov_cnt), 32'h10);

    // short glitch on the line
    rx_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rx_i = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      if (busy_o) saw = 1'b1;
    end
    chk("glitch_busy_seen", 32'(saw), 32'd1);
    chk("glitch_busy_clear", 32'(busy_o), 32'd0);
    chk("glitch_no_byte", 32'(valid_o), 32'd0);
    chk("glitch_flags", 32'(fe_cnt * 16 + ov_cnt), 32'h10);

    // reset in the middle of a frame with one byte buffered
    send(8'h11, 1'b1);
    repeat (3) @(negedge clk_i);
    chk("mid_buffered", 32'(valid_o), 32'd1);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      rx_i = (i < 2);
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = 1'b0;
    repeat (CPB / 2) @(negedge clk_i);
    chk("mid_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_outs",
        32'({valid_o, busy_o, frame_err_o, overrun_o}), 32'd0);
    chk("mid_rst_data", 32'(data_o), 32'd0);
    rx_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    send(8'h99, 1'b1);
    pop_chk("mid_fresh", 8'h99);
    @(negedge clk_i);
    chk("mid_empty", 32'(valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
